// File: rtl/latch_ctrl_pkg.sv
// Shared types and helpers for the latch write sequencer: request opcodes,
// sequencer states and the phase-counter width calculation.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 1) ? 1 : m;
  endfunction

  // The counter loads the phase length and counts down to 1, so it must hold the largest length.
  function automatic int cnt_width(input int s, input int g, input int h);
    return $clog2(max3(s, g, h) + 1);
  endfunction

endpackage

// File: rtl/latch_phase_cnt.sv
// Loadable down-counter shared by the SETUP, PULSE and HOLD phases; `last`
// flags the final cycle of the phase currently loaded.
module latch_phase_cnt
  import latch_ctrl_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/latch_write_ctrl.sv
// Valid/ready sequencer driving a D_latch macro with setup / pulse / hold timing.
// Optional readback check of lat_q in DONE is enabled by defining LATCH_WR_READBACK_EN.
module latch_write_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int LAT_WIDTH = 8,
  parameter int SETUP_CYC = 1,
  parameter int GATE_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [LAT_WIDTH-1:0] req_data,
  output logic                 lat_aset,
  output logic                 lat_gate,
  output logic                 lat_aclr,
  output logic [LAT_WIDTH-1:0] lat_data,
  input  logic [LAT_WIDTH-1:0] lat_q,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CW = cnt_width(SETUP_CYC, GATE_CYC, HOLD_CYC);

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("latch_write_ctrl: SETUP_CYC must be at least 1");
  end
  if (GATE_CYC < 1) begin : g_bad_gate
    $error("latch_write_ctrl: GATE_CYC must be at least 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("latch_write_ctrl: HOLD_CYC must be at least 1");
  end

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [LAT_WIDTH-1:0] lat_data_q, lat_data_d;
  logic                 req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 lat_aset_q, lat_aset_d;
  logic                 lat_gate_q, lat_gate_d;
  logic                 lat_aclr_q, lat_aclr_d;

  logic                 cnt_load;
  logic [CW-1:0]        cnt_val;
  logic                 cnt_en;
  logic                 cnt_last;

  latch_phase_cnt #(.W(CW)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .last     (cnt_last)
  );

  assign cnt_en = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_HOLD);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    lat_data_d = lat_data_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d = op_e'(req_op);
          if (op_d == OP_NOP) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SETUP;
            cnt_load = 1'b1;
            cnt_val  = CW'(SETUP_CYC);
            if (op_d == OP_WRITE) lat_data_d = req_data;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_last) begin
          state_d  = ST_PULSE;
          cnt_load = 1'b1;
          cnt_val  = CW'(GATE_CYC);
        end
      end
      ST_PULSE: begin
        if (cnt_last) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = CW'(HOLD_CYC);
        end
      end
      ST_HOLD: begin
        if (cnt_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered with it.
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    lat_gate_d  = (state_d == ST_PULSE) && (op_d == OP_WRITE);
    lat_aset_d  = (state_d == ST_PULSE) && (op_d == OP_SET);
    lat_aclr_d  = (state_d == ST_PULSE) && (op_d == OP_CLEAR);
  end

`ifdef LATCH_WR_READBACK_EN
  logic [LAT_WIDTH-1:0] exp_q, exp_d;

  // The expected content follows each accept; a nop keeps the previous expectation.
  always_comb begin
    exp_d = exp_q;
    if ((state_q == ST_IDLE) && req_valid && req_ready_q) begin
      unique case (op_e'(req_op))
        OP_WRITE: exp_d = req_data;
        OP_SET:   exp_d = '1;
        OP_CLEAR: exp_d = '0;
        default:  exp_d = exp_q;
      endcase
    end
    err_d = (state_d == ST_DONE) && (lat_q != exp_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end
`else
  logic unused_lat_q;
  assign unused_lat_q = ^lat_q;
  assign err_d        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      lat_data_q  <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lat_aset_q  <= 1'b0;
      lat_gate_q  <= 1'b0;
      lat_aclr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lat_data_q  <= lat_data_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      lat_aset_q  <= lat_aset_d;
      lat_gate_q  <= lat_gate_d;
      lat_aclr_q  <= lat_aclr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign lat_aset  = lat_aset_q;
  assign lat_gate  = lat_gate_q;
  assign lat_aclr  = lat_aclr_q;
  assign lat_data  = lat_data_q;

endmodule
